// File: rtl/dc_sweep_pkg.sv
// Shared definitions for the DC sweep sequencer.
//   state_t      : sequencer FSM states
//   DEF_*        : default widths for DAC codes, ADC samples, point indices and settle counter
package dc_sweep_pkg;

  localparam int DEF_DW = 16;
  localparam int DEF_AW = 16;
  localparam int DEF_NW = 8;
  localparam int DEF_SW = 16;

  typedef enum logic [2:0] {
    IDLE,
    SET,
    SETTLE,
    CONV,
    EMIT,
    DONE
  } state_t;

endpackage

// File: rtl/dc_sweep_sequencer_axis.sv
// sweep_axis_counter: one sweep axis (index plus DAC code accumulator).
//   clk, rst          : clock, synchronous active-high reset
//   load              : latch cfg_start/cfg_step/cfg_n, index to 0, code to cfg_start
//   adv               : step to next point; wraps to index 0 / start code after the last one
//   cfg_start/step/n  : axis configuration (step is two's complement, count 0 means 1)
//   idx, code, last   : current index, current code, index is the final point of the axis
module sweep_axis_counter #(
  parameter int DW = 16,
  parameter int NW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          adv,
  input  logic [DW-1:0] cfg_start,
  input  logic [DW-1:0] cfg_step,
  input  logic [NW-1:0] cfg_n,
  output logic [NW-1:0] idx,
  output logic [DW-1:0] code,
  output logic          last
);

  logic [DW-1:0] start_q;
  logic [DW-1:0] step_q;
  logic [NW-1:0] idx_max_q;

  // Control: index and its terminal value.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      idx_max_q <= '0;
    end else if (load) begin
      idx       <= '0;
      // A count of 0 behaves as a single point.
      idx_max_q <= (cfg_n == '0) ? '0 : cfg_n - NW'(1);
    end else if (adv) begin
      idx <= last ? '0 : idx + NW'(1);
    end
  end

  // Data: code accumulator. Plain modulo-2^DW addition, so a negative step
  // (two's complement) and wrap-around both fall out without saturation.
  always_ff @(posedge clk) begin
    if (load) begin
      start_q <= cfg_start;
      step_q  <= cfg_step;
      code    <= cfg_start;
    end else if (adv) begin
      code <= last ? start_q : code + step_q;
    end
  end

  assign last = (idx == idx_max_q);

endmodule

// File: rtl/dc_sweep_sequencer.sv
// dc_sweep_sequencer: two-axis DC sweep (Vgs outer, Vds inner) with one Id
// capture and one output record per bias point.
//   clk, rst                  : clock, synchronous active-high reset
//   start, abort              : begin sweep (ignored while busy), stop and return to IDLE
//   cfg_vgs_*, cfg_vds_*      : per-axis start code, step, point count (latched on start)
//   cfg_settle                : settle cycles after each DAC update (0 behaves as 1)
//   dac_vgs, dac_vds, dac_load: bias codes and the 1-cycle update strobe
//   adc_req, adc_ack, adc_data: conversion handshake and Id sample
//   rec_*                     : record stream (valid/ready), indices, Id, last flag
//   busy, done                : not idle, 1-cycle sweep-complete pulse
module dc_sweep_sequencer
  import dc_sweep_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW,
  parameter int NW = DEF_NW,
  parameter int SW = DEF_SW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [DW-1:0] cfg_vgs_start,
  input  logic [DW-1:0] cfg_vgs_step,
  input  logic [NW-1:0] cfg_vgs_n,
  input  logic [DW-1:0] cfg_vds_start,
  input  logic [DW-1:0] cfg_vds_step,
  input  logic [NW-1:0] cfg_vds_n,
  input  logic [SW-1:0] cfg_settle,
  output logic [DW-1:0] dac_vgs,
  output logic [DW-1:0] dac_vds,
  output logic          dac_load,
  output logic          adc_req,
  input  logic          adc_ack,
  input  logic [AW-1:0] adc_data,
  output logic          rec_valid,
  input  logic          rec_ready,
  output logic [NW-1:0] rec_gi,
  output logic [NW-1:0] rec_di,
  output logic [AW-1:0] rec_id,
  output logic          rec_last,
  output logic          busy,
  output logic          done
);

  state_t        state_q, state_d;
  logic [SW-1:0] settle_cfg_q;
  logic [SW-1:0] settle_cnt_q;
  logic [AW-1:0] id_q;
  logic [DW-1:0] dac_vgs_q, dac_vds_q;

  logic          accept, hs, pt_last;
  logic [NW-1:0] vgs_idx, vds_idx;
  logic [DW-1:0] vgs_code, vds_code;
  logic          vgs_last, vds_last;

  function automatic logic [SW-1:0] eff_settle(input logic [SW-1:0] s);
    return (s == '0) ? SW'(1) : s;
  endfunction

  assign accept  = (state_q == IDLE) && start && !abort;
  assign hs      = (state_q == EMIT) && rec_ready && !abort;
  assign pt_last = vgs_last && vds_last;

  // Inner axis advances on every accepted record; the outer axis only when
  // the inner one wraps.
  sweep_axis_counter #(.DW(DW), .NW(NW)) u_vgs (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .adv       (hs && vds_last),
    .cfg_start (cfg_vgs_start),
    .cfg_step  (cfg_vgs_step),
    .cfg_n     (cfg_vgs_n),
    .idx       (vgs_idx),
    .code      (vgs_code),
    .last      (vgs_last)
  );

  sweep_axis_counter #(.DW(DW), .NW(NW)) u_vds (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .adv       (hs),
    .cfg_start (cfg_vds_start),
    .cfg_step  (cfg_vds_step),
    .cfg_n     (cfg_vds_n),
    .idx       (vds_idx),
    .code      (vds_code),
    .last      (vds_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      settle_cfg_q <= '0;
      settle_cnt_q <= '0;
      id_q         <= '0;
      dac_vgs_q    <= '0;
      dac_vds_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        settle_cfg_q <= cfg_settle;
      end
      if (state_q == SET) begin
        settle_cnt_q <= eff_settle(settle_cfg_q);
        dac_vgs_q    <= vgs_code;
        dac_vds_q    <= vds_code;
      end else if (state_q == SETTLE) begin
        settle_cnt_q <= settle_cnt_q - SW'(1);
      end
      if ((state_q == CONV) && adc_ack) begin
        id_q <= adc_data;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    dac_load  = 1'b0;
    adc_req   = 1'b0;
    rec_valid = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) state_d = SET;
      end
      SET: begin
        dac_load = 1'b1;
        state_d  = SETTLE;
      end
      SETTLE: begin
        if (settle_cnt_q <= SW'(1)) state_d = CONV;
      end
      CONV: begin
        adc_req = 1'b1;
        if (adc_ack) state_d = EMIT;
      end
      EMIT: begin
        rec_valid = 1'b1;
        if (rec_ready) state_d = pt_last ? DONE : SET;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Abort beats everything, including a start in IDLE.
    if (abort) state_d = IDLE;
  end

  // During SET the new codes come straight from the accumulators so they
  // line up with dac_load; elsewhere the held copy keeps the bias steady even
  // though the accumulators wrap back to their start codes after the last point.
  assign dac_vgs  = (state_q == SET) ? vgs_code : dac_vgs_q;
  assign dac_vds  = (state_q == SET) ? vds_code : dac_vds_q;

  assign rec_gi   = vgs_idx;
  assign rec_di   = vds_idx;
  assign rec_id   = id_q;
  assign rec_last = (state_q == EMIT) && pt_last;

endmodule

// File: tb/tb_dc_sweep_sequencer.sv
module tb_dc_sweep_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [15:0] cfg_vgs_start, cfg_vgs_step, cfg_vds_start, cfg_vds_step;
  logic [7:0]  cfg_vgs_n, cfg_vds_n;
  logic [15:0] cfg_settle;
  logic [15:0] dac_vgs, dac_vds;
  logic        dac_load, adc_req, adc_ack;
  logic [15:0] adc_data;
  logic        rec_valid, rec_ready;
  logic [7:0]  rec_gi, rec_di;
  logic [15:0] rec_id;
  logic        rec_last, busy, done;

  always #5 clk = ~clk;

  dc_sweep_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .abort         (abort),
    .cfg_vgs_start (cfg_vgs_start),
    .cfg_vgs_step  (cfg_vgs_step),
    .cfg_vgs_n     (cfg_vgs_n),
    .cfg_vds_start (cfg_vds_start),
    .cfg_vds_step  (cfg_vds_step),
    .cfg_vds_n     (cfg_vds_n),
    .cfg_settle    (cfg_settle),
    .dac_vgs       (dac_vgs),
    .dac_vds       (dac_vds),
    .dac_load      (dac_load),
    .adc_req       (adc_req),
    .adc_ack       (adc_ack),
    .adc_data      (adc_data),
    .rec_valid     (rec_valid),
    .rec_ready     (rec_ready),
    .rec_gi        (rec_gi),
    .rec_di        (rec_di),
    .rec_id        (rec_id),
    .rec_last      (rec_last),
    .busy          (busy),
    .done          (done)
  );

  typedef struct {
    logic [63:0] fields;  // {gi, di, vgs, vds, id}
    logic        last;
  } rec_t;

  rec_t exp_q[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int hs_cnt = 0;
  int done_cnt = 0;
  int stall_cyc = 0;
  int stall_at = -1;
  int stall_left = 0;
  int exp_settle = 1;
  int ack_delay = 2;
  int conv_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] gi, input logic [7:0] di, input logic [15:0] vgs,
                      input logic [15:0] vds, input logic [15:0] id, input logic last);
    rec_t r;
    r.fields = {gi, di, vgs, vds, id};
    r.last   = last;
    exp_q.push_back(r);
  endtask

  // ADC model: acks ack_delay cycles after req is seen, data = 0x1000 + conversion number.
  initial begin
    int wcnt;
    wcnt     = 0;
    adc_ack  = 1'b0;
    adc_data = 16'h0;
    forever begin
      @(negedge clk);
      if (rst) begin
        adc_ack = 1'b0;
        wcnt    = 0;
      end else if (adc_ack) begin
        adc_ack = 1'b0;
        conv_cnt++;
        wcnt = 0;
      end else if (adc_req) begin
        wcnt++;
        if (wcnt >= ack_delay) begin
          adc_ack  = 1'b1;
          adc_data = 16'h1000 + 16'(conv_cnt);
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Record sink: ready high except for a programmed stall on one record.
  initial begin
    rec_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_left > 0 && rec_valid && hs_cnt == stall_at) begin
        rec_ready = 1'b0;
        stall_left--;
      end else begin
        rec_ready = 1'b1;
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    int          t_load, t_last;
    logic        prev_req, prev_done, held;
    logic [63:0] snap;
    logic        snap_last;
    rec_t        e;
    t_load = 0; t_last = 0;
    prev_req = 1'b0; prev_done = 1'b0; held = 1'b0;
    snap = '0; snap_last = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (dac_load) t_load = cyc;
        if (adc_req && !prev_req) check("set_to_conv_cycles", 64'(cyc - t_load), 64'(exp_settle + 1));
        prev_req = adc_req;
        if (rec_valid) begin
          if (held) begin
            stall_cyc++;
            check("stall_rec_stable", {rec_gi, rec_di, dac_vgs, dac_vds, rec_id, rec_last},
                  {snap, snap_last});
            check("stall_no_req_load", {adc_req, dac_load}, 2'b00);
          end
          if (rec_ready) begin
            hs_cnt++;
            held = 1'b0;
            if (exp_q.size() == 0) begin
              tests++; fails++;
              $display("FAIL unexpected_record: got gi=%0d di=%0d, expected none", rec_gi, rec_di);
            end else begin
              e = exp_q.pop_front();
              check("rec_fields", {rec_gi, rec_di, dac_vgs, dac_vds, rec_id}, e.fields);
              check("rec_last", 64'(rec_last), 64'(e.last));
            end
            if (rec_last) t_last = cyc;
          end else begin
            held      = 1'b1;
            snap      = {rec_gi, rec_di, dac_vgs, dac_vds, rec_id};
            snap_last = rec_last;
          end
        end else begin
          held = 1'b0;
        end
        if (done) begin
          done_cnt++;
          check("done_after_last_rec", 64'(cyc - t_last), 64'd1);
          if (prev_done) check("done_one_cycle", 64'(prev_done), 64'd0);
        end
        prev_done = done;
      end
    end
  end

  task automatic set_cfg(input logic [15:0] gs, input logic [15:0] gst, input logic [7:0] gn,
                         input logic [15:0] ds, input logic [15:0] dst, input logic [7:0] dn,
                         input logic [15:0] st);
    cfg_vgs_start = gs; cfg_vgs_step = gst; cfg_vgs_n = gn;
    cfg_vds_start = ds; cfg_vds_step = dst; cfg_vds_n = dn;
    cfg_settle    = st;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int hs0, input int d0, input int nrec);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt == d0) begin
      tests++; fails++;
      $display("FAIL %s_timeout: got no done, expected done within 3000 cycles", name);
    end
    @(negedge clk);
    check({name, "_idle"}, {busy, done}, 2'b00);
    check({name, "_records"}, 64'(hs_cnt - hs0), 64'(nrec));
    check({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int hs0, d0, n;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    set_cfg(16'h0, 16'h0, 8'd0, 16'h0, 16'h0, 8'd0, 16'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_dac_strobes", {dac_vgs, dac_vds, dac_load, adc_req, rec_valid}, 35'h0);
    check("reset_rec_status", {rec_gi, rec_di, rec_id, rec_last, busy, done}, 35'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic 2x3 sweep.
    exp_settle = 4;
    push(8'd0, 8'd0, 16'h0100, 16'h0000, 16'h1000, 1'b0);
    push(8'd0, 8'd1, 16'h0100, 16'h0400, 16'h1001, 1'b0);
    push(8'd0, 8'd2, 16'h0100, 16'h0800, 16'h1002, 1'b0);
    push(8'd1, 8'd0, 16'h0200, 16'h0000, 16'h1003, 1'b0);
    push(8'd1, 8'd1, 16'h0200, 16'h0400, 16'h1004, 1'b0);
    push(8'd1, 8'd2, 16'h0200, 16'h0800, 16'h1005, 1'b1);
    hs0 = hs_cnt; d0 = done_cnt;
    set_cfg(16'h0100, 16'h0100, 8'd2, 16'h0000, 16'h0400, 8'd3, 16'd4);
    pulse_start();
    wait_done("basic", hs0, d0, 6);

    // Same sweep with the second record held off for 10 cycles.
    push(8'd0, 8'd0, 16'h0100, 16'h0000, 16'h1006, 1'b0);
    push(8'd0, 8'd1, 16'h0100, 16'h0400, 16'h1007, 1'b0);
    push(8'd0, 8'd2, 16'h0100, 16'h0800, 16'h1008, 1'b0);
    push(8'd1, 8'd0, 16'h0200, 16'h0000, 16'h1009, 1'b0);
    push(8'd1, 8'd1, 16'h0200, 16'h0400, 16'h100A, 1'b0);
    push(8'd1, 8'd2, 16'h0200, 16'h0800, 16'h100B, 1'b1);
    hs0 = hs_cnt; d0 = done_cnt;
    stall_cyc  = 0;
    stall_at   = hs_cnt + 1;
    stall_left = 10;
    pulse_start();
    wait_done("stall", hs0, d0, 6);
    check("stall_cycles", 64'(stall_cyc), 64'd10);

    // Zero counts and zero settle: one point, one settle cycle.
    exp_settle = 1;
    push(8'd0, 8'd0, 16'h0333, 16'h0444, 16'h100C, 1'b1);
    hs0 = hs_cnt; d0 = done_cnt;
    set_cfg(16'h0333, 16'h0011, 8'd0, 16'h0444, 16'h0022, 8'd0, 16'd0);
    pulse_start();
    wait_done("single", hs0, d0, 1);

    // Abort while a conversion is pending.
    exp_settle = 4;
    ack_delay  = 1000;
    hs0 = hs_cnt; d0 = done_cnt;
    set_cfg(16'h0100, 16'h0100, 8'd2, 16'h0000, 16'h0400, 8'd3, 16'd4);
    pulse_start();
    n = 0;
    while (!adc_req && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("abort_req_seen", 64'(adc_req), 64'd1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check("abort_outputs", {adc_req, busy, rec_valid, done}, 4'b0000);
    check("abort_dac_hold", {dac_vgs, dac_vds}, {16'h0100, 16'h0000});
    repeat (5) @(negedge clk);
    check("abort_no_done", 64'(done_cnt - d0), 64'd0);
    check("abort_no_records", 64'(hs_cnt - hs0), 64'd0);
    ack_delay = 2;

    // Abort and start together in IDLE: abort wins.
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("abort_beats_start", {busy, dac_load}, 2'b00);

    // Vds code wraps through zero without saturation.
    exp_settle = 2;
    push(8'd0, 8'd0, 16'h0200, 16'hFFF0, 16'h100D, 1'b0);
    push(8'd0, 8'd1, 16'h0200, 16'h0000, 16'h100E, 1'b0);
    push(8'd0, 8'd2, 16'h0200, 16'h0010, 16'h100F, 1'b1);
    hs0 = hs_cnt; d0 = done_cnt;
    set_cfg(16'h0200, 16'h0100, 8'd1, 16'hFFF0, 16'h0010, 8'd3, 16'd2);
    pulse_start();
    wait_done("wrap", hs0, d0, 3);

    // Start and cfg changes while busy are ignored; negative Vgs step.
    exp_settle = 3;
    push(8'd0, 8'd0, 16'h0050, 16'h0007, 16'h1010, 1'b0);
    push(8'd1, 8'd0, 16'h0040, 16'h0007, 16'h1011, 1'b1);
    hs0 = hs_cnt; d0 = done_cnt;
    set_cfg(16'h0050, 16'hFFF0, 8'd2, 16'h0007, 16'h0001, 8'd1, 16'd3);
    pulse_start();
    repeat (3) @(posedge clk);
    #1;
    set_cfg(16'h7777, 16'h0001, 8'd9, 16'h1234, 16'h0002, 8'd9, 16'd3);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("busy_start", hs0, d0, 2);

    repeat (3) @(negedge clk);
    check("no_extra_done", 64'(done_cnt), 64'd5);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
